// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU data-memory request interface.
// Holds the store-width and load-type codes carried on req_wbits/req_rbits,
// the responder state encoding, and a helper that classifies a request's
// code/alignment legality. The CPU control block decodes with the same codes.
package mem_if_pkg;

    // Store width codes (req_wbits); 2'b11 is illegal.
    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    // Load type codes (req_rbits); anything above LD_LBU is illegal.
    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    // Responder FSM encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_RESP = 2'b10
    } dm_state_e;

    // Returns 1 when the width/type code is illegal or the byte offset is
    // misaligned for the access size. Range is checked separately because it
    // depends on the RAM depth.
    function automatic logic code_align_err(input logic       wr,
                                            input logic [1:0] lo,
                                            input logic [1:0] wbits,
                                            input logic [2:0] rbits);
        logic e;
        e = 1'b0;
        if (wr) begin
            case (wbits)
                W_WORD:  e = (lo != 2'b00);
                W_HALF:  e = lo[0];
                W_BYTE:  e = 1'b0;
                default: e = 1'b1;
            endcase
        end else begin
            case (rbits)
                LD_LW:          e = (lo != 2'b00);
                LD_LH, LD_LHU:  e = lo[0];
                LD_LB, LD_LBU:  e = 1'b0;
                default:        e = 1'b1;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Stores: from the byte offset, width code and right-aligned store data,
//   produces the 4-bit byte enable and the lane-replicated write word.
// Loads: from the byte offset, load type and the addressed RAM word,
//   produces the sign- or zero-extended load result.
// Ports:
//   addr_lo_i  byte offset within the word (little-endian lanes)
//   wbits_i    store width code
//   wdata_i    right-aligned store data
//   rbits_i    load type code
//   rword_i    RAM word read at the access index
//   be_o       byte enables, bit n = byte lane n
//   wword_o    write data already positioned in every lane it may hit
//   rdata_o    extended load data
module dm_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  wbits_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  rbits_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [15:0] half_sel_s;
    logic [7:0]  byte_sel_s;

    // Store lane enables and data; the data is replicated so the enables alone
    // pick which copy lands in RAM.
    always_comb begin
        be_o    = 4'b0000;
        wword_o = 32'h0000_0000;
        case (wbits_i)
            W_WORD: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
            end
            W_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {wdata_i[15:0], wdata_i[15:0]};
            end
            W_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            default: begin
                be_o    = 4'b0000;
                wword_o = 32'h0000_0000;
            end
        endcase
    end

    // Field selection from the addressed word.
    always_comb begin
        half_sel_s = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (addr_lo_i)
            2'b00:   byte_sel_s = rword_i[7:0];
            2'b01:   byte_sel_s = rword_i[15:8];
            2'b10:   byte_sel_s = rword_i[23:16];
            2'b11:   byte_sel_s = rword_i[31:24];
            default: byte_sel_s = 8'h00;
        endcase
    end

    // Load extension by type.
    always_comb begin
        case (rbits_i)
            LD_LW:   rdata_o = rword_i;
            LD_LH:   rdata_o = {{16{half_sel_s[15]}}, half_sel_s};
            LD_LHU:  rdata_o = {16'h0000, half_sel_s};
            LD_LB:   rdata_o = {{24{byte_sel_s[7]}}, byte_sel_s};
            LD_LBU:  rdata_o = {24'h00_0000, byte_sel_s};
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the CPU MEM stage.
// Accepts one load/store at a time over a valid/ready handshake, waits
// WAIT_CYCLES cycles, then performs the access on the edge entering RESP and
// holds the response until the CPU takes it.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   req_valid/ready request handshake
//   req_wr          1 = store, 0 = load
//   req_addr        byte address; word index = addr[31:2]
//   req_wdata       right-aligned store data
//   req_wbits       store width code, req_rbits load type code
//   rsp_valid/ready response handshake
//   rsp_rdata       load result, 0 for stores and errors
//   rsp_err         misaligned, out-of-range or illegal-code request
module dm_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_wbits,
    input  logic [2:0]  req_rbits,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          CW        = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int          AW        = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);
    localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);
    localparam logic [29:0] DEPTH_L   = 30'(DEPTH_WORDS);

    dm_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  wbits_q;
    logic [2:0]  rbits_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept_s;
    logic        access_s;
    logic        eff_wr_s;
    logic [31:0] eff_addr_s;
    logic [31:0] eff_wdata_s;
    logic [1:0]  eff_wbits_s;
    logic [2:0]  eff_rbits_s;
    logic [AW-1:0] idx_s;
    logic        err_s;
    logic        mem_we_s;
    logic [3:0]  be_s;
    logic [31:0] wword_s;
    logic [31:0] ld_data_s;

    // ready_q is only ever set while in IDLE, so it alone qualifies acceptance.
    assign accept_s = req_valid & ready_q;

    // With zero wait states the access happens on the acceptance edge, before
    // the latches are loaded, so the live inputs are used while in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            eff_wr_s    = req_wr;
            eff_addr_s  = req_addr;
            eff_wdata_s = req_wdata;
            eff_wbits_s = req_wbits;
            eff_rbits_s = req_rbits;
        end else begin
            eff_wr_s    = wr_q;
            eff_addr_s  = addr_q;
            eff_wdata_s = wdata_q;
            eff_wbits_s = wbits_q;
            eff_rbits_s = rbits_q;
        end
    end

    // Edge on which the FSM enters RESP: memory is touched exactly here.
    always_comb begin
        if (state_q == S_BUSY) begin
            access_s = (cnt_q <= CW'(1));
        end else if (state_q == S_IDLE) begin
            access_s = accept_s & ZERO_WAIT;
        end else begin
            access_s = 1'b0;
        end
    end

    assign idx_s    = eff_addr_s[AW+1:2];
    assign err_s    = (eff_addr_s[31:2] >= DEPTH_L) |
                      code_align_err(eff_wr_s, eff_addr_s[1:0], eff_wbits_s, eff_rbits_s);
    assign mem_we_s = access_s & eff_wr_s & ~err_s;

    dm_lane_align u_lane_align (
        .addr_lo_i (eff_addr_s[1:0]),
        .wbits_i   (eff_wbits_s),
        .wdata_i   (eff_wdata_s),
        .rbits_i   (eff_rbits_s),
        .rword_i   (mem_q[idx_s]),
        .be_o      (be_s),
        .wword_o   (wword_s),
        .rdata_o   (ld_data_s)
    );

    // Next-state, wait counter and ready. Ready rises one cycle after the FSM
    // is back in IDLE, which also keeps it low on the first edge after reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ZERO_WAIT ? S_RESP : S_BUSY;
                    ready_d = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Response payload: captured on the access edge, held through RESP,
    // cleared once the CPU takes it.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = (state_d == S_RESP);
        if (access_s) begin
            err_d   = err_s;
            rdata_d = (err_s | eff_wr_s) ? 32'h0000_0000 : ld_data_s;
        end else if ((state_q == S_RESP) && rsp_ready) begin
            err_d   = 1'b0;
            rdata_d = 32'h0000_0000;
        end else begin
            err_d   = err_q;
            rdata_d = rdata_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request latch, loaded on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wbits_q <= 2'b00;
            rbits_q <= 3'b000;
        end else if (accept_s) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wbits_q <= req_wbits;
            rbits_q <= req_rbits;
        end
    end

    // Word RAM with byte-lane writes; contents are deliberately not reset,
    // and a reset forces IDLE so no pending store can commit.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= wword_s[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_wbits;
    logic [2:0]  req_rbits;

    logic        z_req_valid, z_req_ready, z_req_wr, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [1:0]  z_req_wbits;
    logic [2:0]  z_req_rbits;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  wbits;
        logic [2:0]  rbits;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wbits(req_wbits),
        .req_rbits(req_rbits), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dm_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wr(z_req_wr),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wbits(z_req_wbits),
        .req_rbits(z_req_rbits), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] wbits, input logic [2:0] rbits,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wbits = wbits; v.rbits = rbits;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Issue one request on the WAIT=2 DUT with rsp_ready=1; called right after a negedge.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] wbits, input logic [2:0] rbits,
                          output logic [31:0] rdata, output logic err, output int lat, output bit ok);
        int n;
        ok = 1'b1; rdata = 32'h0; err = 1'b0; lat = 0; n = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        req_wbits = wbits; req_rbits = rbits; rsp_ready = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout actual=0 required=1");
            req_valid = 1'b0; ok = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout actual=0 required=1");
            ok = 1'b0;
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        check("valid_one_cycle", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        logic        zr_exp [7];
        logic        zv_exp [7];
        logic [31:0] zd_exp [7];

        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_wbits = 2'b00; req_rbits = 3'b000; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_wr = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0;
        z_req_wbits = 2'b00; z_req_rbits = 3'b000; z_rsp_ready = 1'b1;

        // Reset state
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        @(negedge clk); @(negedge clk);
        check("rst_held_ready", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        vecs.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10, 32'h0,        2'b00, 3'b000, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h11, 32'h0000007F, 2'b10, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h10, 32'h0,        2'b00, 3'b000, 32'hDEAD7FEF, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13, 32'h0,        2'b00, 3'b011, 32'hFFFFFFDE, 1'b0));
        vecs.push_back(mk(1'b0, 32'h13, 32'h0,        2'b00, 3'b100, 32'h000000DE, 1'b0));
        vecs.push_back(mk(1'b0, 32'h12, 32'h0,        2'b00, 3'b001, 32'hFFFFDEAD, 1'b0));
        vecs.push_back(mk(1'b0, 32'h12, 32'h0,        2'b00, 3'b010, 32'h0000DEAD, 1'b0));
        vecs.push_back(mk(1'b0, 32'h12, 32'h0,        2'b00, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h11, 32'h0000AAAA, 2'b01, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h1000, 32'h0,      2'b00, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h10, 32'h11111111, 2'b11, 3'b000, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 32'h10, 32'h0,        2'b00, 3'b101, 32'h0,        1'b1));
        vecs.push_back(mk(1'b1, 32'h1000, 32'h22222222, 2'b00, 3'b000, 32'h0,      1'b1));
        vecs.push_back(mk(1'b0, 32'h10, 32'h0,        2'b00, 3'b000, 32'hDEAD7FEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h14, 32'h0,        2'b00, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h16, 32'h1234BEEF, 2'b01, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 32'h14, 32'h00000080, 2'b10, 3'b000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 32'h14, 32'h0,        2'b00, 3'b011, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 32'h14, 32'h0,        2'b00, 3'b000, 32'hBEEF0080, 1'b0));
        vecs.push_back(mk(1'b1, 32'h20, 32'h0,        2'b00, 3'b000, 32'h0,        1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wbits, vecs[i].rbits,
                   rd, er, lat, ok);
            if (ok) begin
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
                check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            end
        end

        // Response backpressure
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_rbits = 3'b000;
        rsp_ready = 1'b0;
        lat = 0;
        while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        check("bp_valid_rise", {31'h0, rsp_valid}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), {31'h0, rsp_valid}, 32'h1);
            check($sformatf("bp%0d_rdata", k), rsp_rdata, 32'hDEAD7FEF);
            check($sformatf("bp%0d_err", k), {31'h0, rsp_err}, 32'h0);
            check($sformatf("bp%0d_req_ready", k), {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", {31'h0, rsp_valid}, 32'h0);
        check("bp_hs_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("bp_ready_back", {31'h0, req_ready}, 32'h1);

        // Reset during BUSY of a store
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_wbits = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_no_ready", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'h0, rsp_valid}, 32'h0);
        check("midrst_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk); @(negedge clk);
        // Release with a request already presented: not accepted on the first edge.
        rst_n = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h20; req_rbits = 3'b000;
        @(negedge clk);
        check("rel_ready", {31'h0, req_ready}, 32'h1);
        check("rel_valid", {31'h0, rsp_valid}, 32'h0);
        do_req(1'b0, 32'h20, 32'h0, 2'b00, 3'b000, rd, er, lat, ok);
        if (ok) begin
            check("midrst_lw_rdata", rd, 32'h0);
            check("midrst_lw_err", {31'h0, er}, 32'h0);
            check("midrst_lw_latency", 32'(lat), 32'd3);
        end

        // Zero-wait build: store then back-to-back loads, rsp_ready tied 1
        zr_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        zv_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        zd_exp = '{32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D};
        @(negedge clk);
        check("z_ready_idle", {31'h0, z_req_ready}, 32'h1);
        z_req_valid = 1'b1; z_req_wr = 1'b1; z_req_addr = 32'h0;
        z_req_wdata = 32'hCAFEF00D; z_req_wbits = 2'b00; z_req_rbits = 3'b000;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("z%0d_ready", k), {31'h0, z_req_ready}, {31'h0, zr_exp[k]});
            check($sformatf("z%0d_valid", k), {31'h0, z_rsp_valid}, {31'h0, zv_exp[k]});
            if (zv_exp[k]) begin
                check($sformatf("z%0d_rdata", k), z_rsp_rdata, zd_exp[k]);
                check($sformatf("z%0d_err", k), {31'h0, z_rsp_err}, 32'h0);
            end
            if (k == 0) z_req_wr = 1'b0;
        end
        z_req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
